// File: rtl/dft_pkg.sv
// Shared constants and types for the DFT input staging path.
// Provides the lane/depth geometry, the packed four-lane word and the
// loader state encoding used by dft_x_loader and dft_x_bank.
package dft_pkg;

    localparam int unsigned DFT_DATA_W   = 16;
    localparam int unsigned DFT_LANES    = 4;
    localparam int unsigned DFT_DEPTH    = 32;
    localparam int unsigned DFT_IDX_W    = $clog2(DFT_DEPTH);
    localparam int unsigned DFT_WORD_W   = DFT_LANES * DFT_DATA_W;
    localparam int unsigned DFT_FRAMES_W = 16;

    // One staged word; x0 occupies the least significant lane.
    typedef struct packed {
        logic [DFT_DATA_W-1:0] x3;
        logic [DFT_DATA_W-1:0] x2;
        logic [DFT_DATA_W-1:0] x1;
        logic [DFT_DATA_W-1:0] x0;
    } dft_word_t;

    typedef enum logic [1:0] {
        LD_IDLE   = 2'd0,
        LD_NEXT   = 2'd1,
        LD_STREAM = 2'd2
    } dft_ld_state_e;

endpackage

// File: rtl/dft_x_bank.sv
// One frame bank: DFT_DEPTH words of four lanes held in flops.
// Ports:
//   clk        rising-edge clock for the write port
//   we         write enable
//   waddr      write word index
//   wdata      word to store
//   raddr      read word index
//   rd_data_c  combinational read of mem[raddr]
// Contents are deliberately not reset; a frame is always written before use.
module dft_x_bank
    import dft_pkg::*;
(
    input  logic                 clk,
    input  logic                 we,
    input  logic [DFT_IDX_W-1:0] waddr,
    input  dft_word_t            wdata,
    input  logic [DFT_IDX_W-1:0] raddr,
    output dft_word_t            rd_data_c
);

    dft_word_t mem [DFT_DEPTH];

    // Synchronous write port
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Asynchronous read port
    assign rd_data_c = mem[raddr];

endmodule

// File: rtl/dft_x_loader.sv
// Ping-pong input staging buffer feeding the DFT core.
// The host fills one bank while the other streams; start swaps banks,
// pulses next for one cycle, then presents the frame on X0..X3 for
// DEPTH consecutive cycles. One extra start can be queued while busy.
// Ports:
//   clk      rising-edge clock
//   reset    synchronous, active-high
//   wr_en    write one word into the fill bank
//   wr_idx   word index of the write
//   wr_data  lane0=[15:0] ... lane3=[63:48]
//   start    one-cycle launch request
//   next     one-cycle frame-start pulse to the DFT core
//   X0..X3   streamed samples, 0 when not streaming
//   busy     a frame is in its NEXT or STREAM phase
//   pending  a queued start is waiting
//   ovf      sticky: a start was dropped because the queue was full
//   wr_drop  sticky: a write was dropped because the fill bank is locked
//   frames   number of next pulses, wraps modulo 2^16
module dft_x_loader
    import dft_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    wr_en,
    input  logic [DFT_IDX_W-1:0]    wr_idx,
    input  logic [DFT_WORD_W-1:0]   wr_data,
    input  logic                    start,
    output logic                    next,
    output logic [DFT_DATA_W-1:0]   X0,
    output logic [DFT_DATA_W-1:0]   X1,
    output logic [DFT_DATA_W-1:0]   X2,
    output logic [DFT_DATA_W-1:0]   X3,
    output logic                    busy,
    output logic                    pending,
    output logic                    ovf,
    output logic                    wr_drop,
    output logic [DFT_FRAMES_W-1:0] frames
);

    localparam int unsigned IDX_W    = DFT_IDX_W;
    localparam int unsigned LAST_IDX = DFT_DEPTH - 1;

    dft_ld_state_e    state;
    logic             fill_bank;
    logic [IDX_W-1:0] cnt;
    dft_word_t        x_q;

    dft_word_t        wr_word_c;
    dft_word_t        rd0_c;
    dft_word_t        rd1_c;
    dft_word_t        rd_word_c;
    logic [IDX_W-1:0] rd_idx_c;
    logic             we0_c;
    logic             we1_c;
    logic             last_c;
    logic             queue_c;

    // Write steering: the fill bank is locked while a start is queued
    assign wr_word_c = dft_word_t'(wr_data);
    assign we0_c     = wr_en && !pending && !fill_bank;
    assign we1_c     = wr_en && !pending &&  fill_bank;

    // Read address runs one word ahead of cnt since X is registered
    assign last_c    = (state == LD_STREAM) && (cnt == IDX_W'(LAST_IDX));
    assign rd_idx_c  = (state == LD_STREAM) ? IDX_W'(cnt + IDX_W'(1)) : '0;
    assign rd_word_c = fill_bank ? rd0_c : rd1_c;

    // Starts that arrive mid-frame are queued; the final stream cycle
    // handles its own start as an immediate relaunch
    assign queue_c   = start && ((state == LD_NEXT) || ((state == LD_STREAM) && !last_c));

    dft_x_bank u_bank0 (
        .clk       (clk),
        .we        (we0_c),
        .waddr     (wr_idx),
        .wdata     (wr_word_c),
        .raddr     (rd_idx_c),
        .rd_data_c (rd0_c)
    );

    dft_x_bank u_bank1 (
        .clk       (clk),
        .we        (we1_c),
        .waddr     (wr_idx),
        .wdata     (wr_word_c),
        .raddr     (rd_idx_c),
        .rd_data_c (rd1_c)
    );

    // Loader FSM with registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= LD_IDLE;
            fill_bank <= 1'b0;
            cnt       <= '0;
            next      <= 1'b0;
            x_q       <= '0;
            busy      <= 1'b0;
            pending   <= 1'b0;
            ovf       <= 1'b0;
            wr_drop   <= 1'b0;
            frames    <= '0;
        end else begin
            next <= 1'b0;

            if (wr_en && pending) begin
                wr_drop <= 1'b1;
            end

            if (queue_c) begin
                if (pending) begin
                    ovf <= 1'b1;
                end else begin
                    pending <= 1'b1;
                end
            end

            unique case (state)
                LD_IDLE: begin
                    if (start) begin
                        fill_bank <= ~fill_bank;
                        state     <= LD_NEXT;
                        next      <= 1'b1;
                        busy      <= 1'b1;
                        frames    <= frames + DFT_FRAMES_W'(1);
                    end
                end

                LD_NEXT: begin
                    state <= LD_STREAM;
                    cnt   <= '0;
                    x_q   <= rd_word_c;
                end

                LD_STREAM: begin
                    if (last_c) begin
                        x_q <= '0;
                        if (pending || start) begin
                            // Back-to-back frame: swap banks without an idle gap
                            fill_bank <= ~fill_bank;
                            pending   <= 1'b0;
                            state     <= LD_NEXT;
                            next      <= 1'b1;
                            frames    <= frames + DFT_FRAMES_W'(1);
                            if (pending && start) begin
                                ovf <= 1'b1;
                            end
                        end else begin
                            state <= LD_IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        x_q <= rd_word_c;
                        cnt <= IDX_W'(cnt + IDX_W'(1));
                    end
                end

                default: begin
                    state <= LD_IDLE;
                end
            endcase
        end
    end

    assign X0 = x_q.x0;
    assign X1 = x_q.x1;
    assign X2 = x_q.x2;
    assign X3 = x_q.x3;

endmodule

// File: tb/tb_dft_x_loader.sv
// Self-checking bench for dft_x_loader: a frame-level model plus directed
// scenarios with hand-computed literal expectations.
module tb_dft_x_loader;
    import dft_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        wr_en;
    logic [4:0]  wr_idx;
    logic [63:0] wr_data;
    logic        start;
    logic        next;
    logic [15:0] X0, X1, X2, X3;
    logic        busy, pending, ovf, wr_drop;
    logic [15:0] frames;

    always #5 clk = ~clk;

    dft_x_loader dut (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_en),
        .wr_idx  (wr_idx),
        .wr_data (wr_data),
        .start   (start),
        .next    (next),
        .X0      (X0),
        .X1      (X1),
        .X2      (X2),
        .X3      (X3),
        .busy    (busy),
        .pending (pending),
        .ovf     (ovf),
        .wr_drop (wr_drop),
        .frames  (frames)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Frame-level model: phase -1 idle, 0 the next cycle, 1..32 word phase-1 shown
    logic [63:0] m_mem [2][32];
    logic [63:0] m_frame [32];
    int          m_phase  = -1;
    bit          m_fill   = 1'b0;
    bit          m_pend   = 1'b0;
    bit          m_ovf    = 1'b0;
    bit          m_wdrop  = 1'b0;
    int          m_frames = 0;
    bit          m_valid  = 1'b0;

    always @(posedge clk) begin
        bit launch;
        launch = 1'b0;
        if (wr_en && !m_pend) m_mem[m_fill][wr_idx] = wr_data;
        if (reset) begin
            m_phase  = -1;
            m_fill   = 1'b0;
            m_pend   = 1'b0;
            m_ovf    = 1'b0;
            m_wdrop  = 1'b0;
            m_frames = 0;
            m_valid  = 1'b1;
        end else begin
            if (wr_en && m_pend) m_wdrop = 1'b1;
            if (m_phase < 0) begin
                if (start) launch = 1'b1;
            end else if (m_phase == 32) begin
                if (m_pend || start) begin
                    launch = 1'b1;
                    if (m_pend && start) m_ovf = 1'b1;
                    m_pend = 1'b0;
                end else begin
                    m_phase = -1;
                end
            end else begin
                if (start) begin
                    if (m_pend) m_ovf = 1'b1;
                    else        m_pend = 1'b1;
                end
                m_phase++;
            end
            if (launch) begin
                for (int i = 0; i < 32; i++) m_frame[i] = m_mem[m_fill][i];
                m_fill   = !m_fill;
                m_phase  = 0;
                m_frames = m_frames + 1;
            end
        end
    end

    // Per-cycle comparison of every output against the model
    always @(negedge clk) begin
        logic [63:0] ex;
        if (m_valid) begin
            ex = (m_phase >= 1) ? m_frame[m_phase-1] : 64'd0;
            chk("m_next",    64'(next),    64'(m_phase == 0));
            chk("m_busy",    64'(busy),    64'(m_phase >= 0));
            chk("m_pending", 64'(pending), 64'(m_pend));
            chk("m_ovf",     64'(ovf),     64'(m_ovf));
            chk("m_wr_drop", 64'(wr_drop), 64'(m_wdrop));
            chk("m_frames",  64'(frames),  64'(m_frames[15:0]));
            chk("m_X",       {X3, X2, X1, X0}, ex);
        end
    end

    function automatic logic [63:0] ramp(input int j, input int off);
        return {16'(4*j+3+off), 16'(4*j+2+off), 16'(4*j+1+off), 16'(4*j+off)};
    endfunction

    task automatic step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic write_ramp(input int off);
        for (int j = 0; j < 32; j++) begin
            wr_en   = 1'b1;
            wr_idx  = 5'(j);
            wr_data = ramp(j, off);
            step();
        end
        wr_en = 1'b0;
    endtask

    initial begin
        reset = 1'b1; wr_en = 1'b0; start = 1'b0; wr_idx = '0; wr_data = '0;
        repeat (2) step();
        chk("rst_busy",   64'(busy),   64'd0);
        chk("rst_next",   64'(next),   64'd0);
        chk("rst_frames", 64'(frames), 64'd0);
        chk("rst_X0",     64'(X0),     64'd0);
        reset = 1'b0;

        // Ramp frame from bank 0
        write_ramp(0);
        start = 1'b1; step(); start = 1'b0;
        chk("ramp_next", 64'(next), 64'd1);
        chk("ramp_busy", 64'(busy), 64'd1);
        step();
        chk("ramp_w0_X0", 64'(X0), 64'd0);
        chk("ramp_w0_X3", 64'(X3), 64'd3);
        repeat (31) step();
        chk("ramp_w31_X0", 64'(X0), 64'd124);
        chk("ramp_w31_X3", 64'(X3), 64'd127);
        step();
        chk("ramp_end_busy",   64'(busy),   64'd0);
        chk("ramp_end_X0",     64'(X0),     64'd0);
        chk("ramp_end_frames", 64'(frames), 64'd1);

        // Ping-pong: A streams bank 0 ramp while ramp+128 fills bank 1
        do_reset();
        start = 1'b1; step(); start = 1'b0;
        for (int j = 0; j < 32; j++) begin
            wr_en = 1'b1; wr_idx = 5'(j); wr_data = ramp(j, 128);
            start = (j == 31);
            step();
        end
        wr_en = 1'b0; start = 1'b0;
        chk("pp_pending", 64'(pending), 64'd1);
        chk("pp_A_w31",   64'(X0),      64'd124);
        step();
        chk("pp_B_next",    64'(next),    64'd1);
        chk("pp_pend_clr",  64'(pending), 64'd0);
        chk("pp_frames",    64'(frames),  64'd2);
        step();
        chk("pp_B_w0_X0", 64'(X0), 64'd128);
        chk("pp_B_w0_X3", 64'(X3), 64'd131);
        repeat (31) step();
        chk("pp_B_w31_X0", 64'(X0), 64'd252);
        chk("pp_B_w31_X3", 64'(X3), 64'd255);
        step();
        chk("pp_end_busy", 64'(busy), 64'd0);

        // Overflow and dropped write
        do_reset();
        start = 1'b1; step();
        step();
        chk("ov_pending", 64'(pending), 64'd1);
        step(); start = 1'b0;
        chk("ov_ovf", 64'(ovf), 64'd1);
        wr_en = 1'b1; wr_idx = 5'd0; wr_data = 64'hDEAD_BEEF_DEAD_BEEF; step(); wr_en = 1'b0;
        chk("ov_wr_drop", 64'(wr_drop), 64'd1);
        repeat (31) step();
        chk("ov_B_w0_X0", 64'(X0), 64'd128);
        repeat (32) step();
        chk("ov_end_busy",   64'(busy),   64'd0);
        chk("ov_end_frames", 64'(frames), 64'd2);
        chk("ov_sticky",     64'(ovf),    64'd1);

        // Write and start in the same idle cycle
        wr_en = 1'b1; wr_idx = 5'd0; wr_data = 64'hAAAA_BBBB_CCCC_DDDD; start = 1'b1;
        step();
        wr_en = 1'b0; start = 1'b0;
        step();
        chk("sc_X0", 64'(X0), 64'hDDDD);
        chk("sc_X1", 64'(X1), 64'hCCCC);
        chk("sc_X2", 64'(X2), 64'hBBBB);
        chk("sc_X3", 64'(X3), 64'hAAAA);
        repeat (33) step();

        // Reset in the middle of a frame, then a clean frame
        start = 1'b1; step(); start = 1'b0;
        repeat (11) step();
        chk("mr_w10_X0", 64'(X0), 64'd168);
        do_reset();
        chk("mr_X0",     64'(X0),     64'd0);
        chk("mr_next",   64'(next),   64'd0);
        chk("mr_busy",   64'(busy),   64'd0);
        chk("mr_frames", 64'(frames), 64'd0);
        start = 1'b1; step(); start = 1'b0;
        step();
        chk("mr_new_w0_X0", 64'(X0), 64'hDDDD);
        step();
        chk("mr_new_w1_X0", 64'(X0), 64'd4);
        repeat (34) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
